// File: rtl/edge_counter_pkg.sv
// Shared definitions for the multi-channel edge counter: register offsets,
// count-mode encodings and the CTRL register layout.
package edge_counter_pkg;

  // Word offsets (addr[3:2]) inside a channel block
  localparam logic [1:0] OFF_CTRL    = 2'd0;
  localparam logic [1:0] OFF_COUNT   = 2'd1;
  localparam logic [1:0] OFF_COMPARE = 2'd2;
  localparam logic [1:0] OFF_SNAP    = 2'd3;

  // Word offsets inside the global block
  localparam logic [1:0] OFF_STATUS  = 2'd0;
  localparam logic [1:0] OFF_CMD     = 2'd1;

  // Block index (addr[6:4]) of the global registers
  localparam logic [2:0] GLOBAL_BLK  = 3'd7;

  // Which synchronised edge a channel counts
  typedef enum logic [1:0] {
    MODE_RISE = 2'b00,
    MODE_FALL = 2'b01,
    MODE_BOTH = 2'b10,
    MODE_NONE = 2'b11
  } mode_e;

  // CTRL register: [3] irq_en, [2:1] mode, [0] en
  typedef struct packed {
    logic  irq_en;
    mode_e mode;
    logic  en;
  } ctrl_t;

endpackage

// File: rtl/edge_counter_multi_if.sv
// Register bus shared by all channels: byte address, write data/strobe and
// combinational read data.
interface edge_counter_multi_if;
  logic [6:0]  addr;
  logic [31:0] data_in;
  logic        data_write;
  logic [31:0] data_out;

  modport master (output addr, output data_in, output data_write, input data_out);
  modport slave  (input addr, input data_in, input data_write, output data_out);
endinterface

// File: rtl/edge_counter_ch.sv
// One counting channel: input synchroniser, edge detector, counter with
// compare, snapshot register and sticky match/overflow flags.
module edge_counter_ch
  import edge_counter_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sig_i,
  input  logic             ctrl_we_i,
  input  ctrl_t            ctrl_wdata_i,
  input  logic             count_we_i,
  input  logic             cmp_we_i,
  input  logic [CNT_W-1:0] wdata_i,
  input  logic             clr_i,
  input  logic             snap_i,
  input  logic             match_clr_i,
  input  logic             ovf_clr_i,
  output ctrl_t            ctrl_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [CNT_W-1:0] cmp_o,
  output logic [CNT_W-1:0] snap_o,
  output logic             match_o,
  output logic             ovf_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  ctrl_t                  ctrl_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cmp_q, snap_q, cnt_inc;
  logic                   match_q, match_d, ovf_q, ovf_d;
  logic                   s, rise, fall, hit, load, inc;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

  // Select the edge type this channel counts
  always_comb begin
    hit = 1'b0;
    case (ctrl_q.mode)
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
  end

  // Counter next state; a bus load or clear pre-empts a same-cycle edge,
  // and only a real increment can raise match/overflow
  always_comb begin
    load    = count_we_i | clr_i;
    inc     = ctrl_q.en & hit & ~load;
    cnt_inc = cnt_q + CNT_W'(1);
    cnt_d   = cnt_q;
    if (count_we_i)   cnt_d = wdata_i;
    else if (clr_i)   cnt_d = '0;
    else if (inc)     cnt_d = cnt_inc;
    match_d = (match_q & ~match_clr_i) | (inc & (cnt_inc == cmp_q));
    ovf_d   = (ovf_q & ~ovf_clr_i) | (inc & (cnt_q == '1));
  end

  // Pipeline, registers and sticky flags; prev follows the input regardless of en
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      snap_q  <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_i};
      prev_q  <= s;
      if (ctrl_we_i) ctrl_q <= ctrl_wdata_i;
      if (cmp_we_i)  cmp_q  <= wdata_i;
      if (snap_i)    snap_q <= cnt_q;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ctrl_o  = ctrl_q;
  assign cnt_o   = cnt_q;
  assign cmp_o   = cmp_q;
  assign snap_o  = snap_q;
  assign match_o = match_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/edge_counter_multi.sv
// Multi-channel edge counter: address decode, CMD/STATUS handling,
// read mux and the shared level interrupt.
module edge_counter_multi
  import edge_counter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_CH-1:0]     sig_in,
  edge_counter_multi_if.slave   bus,
  output logic                  irq
);

  logic [2:0]        blk;
  logic [1:0]        off;
  logic              glob_we, status_we, snap_all, clr_all;
  logic [NUM_CH-1:0] match_v, ovf_v, irq_en_v;
  ctrl_t             ctrl_a [NUM_CH];
  logic [CNT_W-1:0]  cnt_a  [NUM_CH];
  logic [CNT_W-1:0]  cmp_a  [NUM_CH];
  logic [CNT_W-1:0]  snap_a [NUM_CH];
  logic [31:0]       status, rdata;
  logic              unused_bits;

  assign blk       = bus.addr[6:4];
  assign off       = bus.addr[3:2];
  assign glob_we   = bus.data_write && (blk == GLOBAL_BLK);
  assign status_we = glob_we && (off == OFF_STATUS);
  assign snap_all  = glob_we && (off == OFF_CMD) && bus.data_in[0];
  assign clr_all   = glob_we && (off == OFF_CMD) && bus.data_in[1];
  assign unused_bits = ^{bus.addr[1:0], bus.data_in};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic ch_we;
    assign ch_we = bus.data_write && (blk == 3'(g));

    edge_counter_ch #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .sig_i        (sig_in[g]),
      .ctrl_we_i    (ch_we && (off == OFF_CTRL)),
      .ctrl_wdata_i (ctrl_t'(bus.data_in[3:0])),
      .count_we_i   (ch_we && (off == OFF_COUNT)),
      .cmp_we_i     (ch_we && (off == OFF_COMPARE)),
      .wdata_i      (bus.data_in[CNT_W-1:0]),
      .clr_i        (clr_all),
      .snap_i       (snap_all),
      .match_clr_i  (status_we && bus.data_in[g]),
      .ovf_clr_i    (status_we && bus.data_in[8+g]),
      .ctrl_o       (ctrl_a[g]),
      .cnt_o        (cnt_a[g]),
      .cmp_o        (cmp_a[g]),
      .snap_o       (snap_a[g]),
      .match_o      (match_v[g]),
      .ovf_o        (ovf_v[g])
    );

    assign irq_en_v[g] = ctrl_a[g].irq_en;
  end

  // STATUS assembly: match flags in the low byte, overflow flags from bit 8
  always_comb begin
    status = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      status[n]   = match_v[n];
      status[8+n] = ovf_v[n];
    end
  end

  // Combinational read mux; unmapped locations and CMD read as zero
  always_comb begin
    rdata = '0;
    if (blk == GLOBAL_BLK) begin
      if (off == OFF_STATUS) rdata = status;
    end else begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (blk == 3'(n)) begin
          case (off)
            OFF_CTRL:    rdata = {28'd0, ctrl_a[n]};
            OFF_COUNT:   rdata = 32'(cnt_a[n]);
            OFF_COMPARE: rdata = 32'(cmp_a[n]);
            default:     rdata = 32'(snap_a[n]);
          endcase
        end
      end
    end
  end

  assign bus.data_out = rdata;
  assign irq          = |((match_v | ovf_v) & irq_en_v);

endmodule

// File: tb/tb_edge_counter_multi.sv
// Directed self-checking bench for edge_counter_multi (4 channels, 16-bit).
module tb_edge_counter_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sig_in = '0;
  logic       irq;
  int         n_checks = 0;
  int         n_fail = 0;

  edge_counter_multi_if bus_if ();

  edge_counter_multi #(
    .NUM_CH      (4),
    .CNT_W       (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .bus    (bus_if),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.addr = a; bus_if.data_in = d; bus_if.data_write = 1'b1;
    @(negedge clk);
    bus_if.data_write = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
    bus_if.addr = a;
    #1;
    check_eq(tag, bus_if.data_out, exp);
  endtask

  // Full pulse on the masked channels: 3 cycles high, 3 cycles low
  task automatic pulse(input logic [3:0] m);
    @(negedge clk);
    sig_in = m;
    repeat (3) @(negedge clk);
    sig_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulses(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) pulse(m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] a;
    int tgt [4];
    bus_if.addr = '0; bus_if.data_in = '0; bus_if.data_write = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_irq", irq, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state of every register
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 4; o++) begin
        a = 7'(c * 16 + o * 4);
        rd_chk($sformatf("rst_%02h", a), a, 0);
      end
    rd_chk("rst_status", 7'h70, 0);
    rd_chk("rst_cmd", 7'h74, 0);
    check_eq("rst_irq2", irq, 0);

    // ch0 rising edges
    wr(7'h00, 32'h1);
    rd_chk("ctrl0", 7'h00, 32'h1);
    pulses(4'b0001, 5);
    rd_chk("cnt0_5", 7'h04, 5);
    rd_chk("cnt1_0", 7'h14, 0);
    rd_chk("cnt2_0", 7'h24, 0);
    rd_chk("cnt3_0", 7'h34, 0);

    // ch1 both / fall / none
    wr(7'h10, 32'h5);
    pulses(4'b0010, 3);
    rd_chk("cnt1_both", 7'h14, 6);
    wr(7'h10, 32'h3);
    pulses(4'b0010, 3);
    rd_chk("cnt1_fall", 7'h14, 9);
    wr(7'h10, 32'h7);
    pulses(4'b0010, 3);
    rd_chk("cnt1_none", 7'h14, 9);

    // ch2 compare match and irq
    wr(7'h28, 4);
    wr(7'h20, 32'h9);
    pulses(4'b0100, 3);
    rd_chk("st_pre_match", 7'h70, 0);
    check_eq("irq_pre_match", irq, 0);
    pulse(4'b0100);
    rd_chk("st_match2", 7'h70, 32'h4);
    check_eq("irq_match2", irq, 1);
    wr(7'h70, 32'h4);
    rd_chk("st_w1c", 7'h70, 0);
    check_eq("irq_w1c", irq, 0);
    wr(7'h24, 4);
    rd_chk("cnt2_load", 7'h24, 4);
    rd_chk("st_load_nomatch", 7'h70, 0);
    wr(7'h24, 3);
    pulse(4'b0100);
    check_eq("irq_match2b", irq, 1);
    wr(7'h20, 32'h1);
    check_eq("irq_masked", irq, 0);
    rd_chk("st_masked", 7'h70, 32'h4);
    wr(7'h70, 32'h4);

    // ch3 wrap: COMPARE3=0 so match accompanies overflow
    wr(7'h30, 32'h1);
    wr(7'h34, 32'hFFFF);
    pulse(4'b1000);
    rd_chk("cnt3_wrap", 7'h34, 0);
    rd_chk("st_wrap", 7'h70, 32'h808);
    wr(7'h70, 32'h808);
    rd_chk("st_wrap_clr", 7'h70, 0);
    wr(7'h30, 32'h0);
    @(negedge clk); sig_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    wr(7'h30, 32'h1);
    repeat (5) @(negedge clk);
    rd_chk("cnt3_no_phantom", 7'h34, 0);
    sig_in[3] = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk("cnt3_dis_fall", 7'h34, 0);

    // Counts 7/2/9/1 then snapshot + clear together
    for (int c = 0; c < 4; c++) wr(7'(c * 16), 32'h1);
    wr(7'h74, 32'h2);
    rd_chk("cnt2_cleared", 7'h24, 0);
    tgt = '{7, 2, 9, 1};
    for (int i = 0; i < 9; i++)
      pulse({tgt[3] > i, tgt[2] > i, tgt[1] > i, tgt[0] > i});
    rd_chk("cnt2_9", 7'h24, 9);
    wr(7'h74, 32'h3);
    for (int c = 0; c < 4; c++) begin
      rd_chk($sformatf("snap%0d", c), 7'(c * 16 + 12), 32'(tgt[c]));
      rd_chk($sformatf("cnt%0d_clr", c), 7'(c * 16 + 4), 0);
    end
    rd_chk("cmd_read", 7'h74, 0);

    // Edge and COUNT0 write in the same cycle: write wins
    @(negedge clk); sig_in[0] = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    bus_if.addr = 7'h04; bus_if.data_in = 32'h10; bus_if.data_write = 1'b1;
    @(negedge clk);
    bus_if.data_write = 1'b0;
    repeat (3) @(negedge clk);
    rd_chk("cnt0_collide", 7'h04, 32'h10);
    sig_in[0] = 1'b0;
    repeat (3) @(negedge clk);
    pulse(4'b0001);
    rd_chk("cnt0_after", 7'h04, 32'h11);

    // Asynchronous reset with flags set (ch2 matched at 4 while counting to 9)
    wr(7'h20, 32'h9);
    check_eq("irq_pre_rst", irq, 1);
    bus_if.addr = 7'h70;
    @(negedge clk); sig_in = 4'b0001;
    #3 rst_n = 1'b0;
    #1;
    check_eq("irq_async_rst", irq, 0);
    check_eq("st_async_rst", bus_if.data_out, 0);
    sig_in = '0;
    for (int c = 0; c < 4; c++)
      for (int o = 0; o < 4; o++) begin
        a = 7'(c * 16 + o * 4);
        rd_chk($sformatf("rst2_%02h", a), a, 0);
      end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr(7'h00, 32'h1);
    pulse(4'b0001);
    rd_chk("cnt0_post_rst", 7'h04, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_counter_multi.md
Name: edge_counter_multi

Overview:
Multi-channel successor to the single edge-counter peripheral. Each of NUM_CH asynchronous inputs has its own synchroniser, edge detector, CNT_W-bit counter, compare register and sticky flags. An atomic snapshot captures all counters in the same cycle. All channels share one register bus and one level interrupt. It sits behind the top-level TinyTapeout/TinyQV wrapper, with sig_in driven from ui_in.

Parameters:
NUM_CH, 4, number of channels (1..7)
CNT_W, 16, counter/compare/snapshot width (1..32)
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
sig_in  in  NUM_CH  asynchronous inputs to count
addr  in  7  byte address; addr[1:0] ignored
data_in  in  32  write data
data_write  in  1  one-cycle write strobe
data_out  out  32  read data, combinational from addr
irq  out  1  OR over channels of (match|ovf) & irq_en

Behaviour:
- Address map, ch n = addr[6:4] < NUM_CH:
  - +0x0 CTRL: [0] en, [2:1] mode (00 rise, 01 fall, 10 both, 11 none), [3] irq_en
  - +0x4 COUNT: read value; write loads data_in[CNT_W-1:0]
  - +0x8 COMPARE: R/W
  - +0xC SNAP: read-only
- Global block, addr[6:4]=7:
  - 0x70 STATUS: [n] match_n, [8+n] ovf_n; write-1-to-clear
  - 0x74 CMD: write bit0=1 snapshots all channels; bit1=1 zeroes all counters; reads 0
- Unmapped reads return 0; unmapped writes ignored. Upper data_out bits above CNT_W are 0.
- Reset values: all CTRL, COUNT, COMPARE, SNAP, STATUS = 0; synchroniser and edge flops = 0; data_out reflects regs (0 at addr 0); irq=0.
- Input pipeline: SYNC_STAGES flops, then one prev flop.
  - rise = s & ~prev; fall = ~s & prev.
  - prev updates every cycle regardless of en, so enabling a channel never produces a phantom edge.
- Latency: a level change on sig_in, stable for 2+ cycles, increments COUNT on the edge at cycle SYNC_STAGES+1 after capture.
- Count: if en and the selected edge is present, COUNT <= COUNT+1 modulo 2^CNT_W.
  - Wrap from all-ones to 0 sets ovf_n.
  - Pulses shorter than one clk period may be missed; this is not an error.
- Match: when an increment produces COUNT_next == COMPARE, set match_n.
  - Loads via bus never set match.
  - COMPARE=0 matches only on wrap, where ovf also sets.
- Flags are sticky until W1C.
  - Same-cycle set and clear: set wins, so no event is lost.
- Same-cycle bus write to COUNT (or CMD clear) and a counted edge: write wins, the edge is dropped, and match/ovf are not evaluated.
- Snapshot: SNAP_n <= COUNT_n (pre-increment value of that cycle) for all n in the same cycle.
  - CMD bit0 and bit1 together: snapshot takes the old values, then counters clear.
- irq is registered-free: combinational OR of flag&irq_en.
  - Clearing irq_en masks it without clearing flags.
- Reset assertion mid-count clears everything asynchronously. The first edge after release is counted normally once the pipeline refills.

Decomposition:
- Package edge_counter_pkg:
  - register offsets (CTRL/COUNT/COMPARE/SNAP, STATUS, CMD)
  - mode encodings (MODE_RISE, MODE_FALL, MODE_BOTH, MODE_NONE)
  - GLOBAL_BLK = 3'd7
- One sub-module, edge_counter_ch, instantiated NUM_CH times via generate: synchroniser, edge detect, counter, compare, flags.
- Top keeps address decode, snapshot/CMD fan-out, STATUS assembly and the irq OR.

Test Plan:
- Reset, then read all regs -> all 0, irq=0. Set CTRL0=0x1, drive 5 rising pulses on sig_in[0] -> COUNT0=5, others 0.
- ch1 mode=10 (both), 3 full pulses -> COUNT1=6. mode=01 -> +3 per 3 pulses. mode=11 -> unchanged.
- COMPARE2=4, CTRL2=0x9, 4 rising edges -> STATUS[2]=1 and irq=1. W1C 0x4 -> irq=0. Load COUNT2=4 -> no match.
- CNT_W=16: load COUNT3=0xFFFF, 1 edge -> COUNT3=0, STATUS[11]=1. Hold sig_in[3] high, set en -> no count.
- Counts 7/2/9/1, write CMD=0x3 -> SNAP=7/2/9/1, COUNTs=0. Edge in the same cycle as a COUNT0 write of 0x10 -> COUNT0=0x10.
- Assert rst_n low mid-stream with flags set -> all regs 0 and irq=0 immediately.
